// File: rtl/time_display_scanner_if.sv
// Bundle between the time counters and the 4-digit multiplexed display:
// time word and display controls in, anode/segment/dp pins out.
interface time_display_scanner_if;
    logic [12:0] count;
    logic        en;
    logic [3:0]  blink_mask;
    logic        colon_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output count, en, blink_mask, colon_en,
        input  an, seg, dp
    );

    modport slave (
        input  count, en, blink_mask, colon_en,
        output an, seg, dp
    );
endinterface

// File: rtl/time_display_scanner.sv
// Scans a packed BCD time word onto a 4-digit common-anode display, one digit
// per refresh slot, with per-frame snapshot, per-digit blink and dash on bad BCD.
module time_display_scanner #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_TICKS = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    time_display_scanner_if.slave  bus
);
    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [6:0]    SEG_OFF    = 7'b1111111;
    localparam logic [6:0]    SEG_DASH   = 7'b0111111;

    // Active-low gfedcba code for one digit; anything above its limit shows a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] val, input logic [3:0] lim);
        logic [6:0] code;
        if (val > lim) begin
            code = SEG_DASH;
        end else begin
            case (val)
                4'd0:    code = 7'b1000000;
                4'd1:    code = 7'b1111001;
                4'd2:    code = 7'b0100100;
                4'd3:    code = 7'b0110000;
                4'd4:    code = 7'b0011001;
                4'd5:    code = 7'b0010010;
                4'd6:    code = 7'b0000010;
                4'd7:    code = 7'b1111000;
                4'd8:    code = 7'b0000000;
                4'd9:    code = 7'b0010000;
                default: code = SEG_DASH;
            endcase
        end
        return code;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [12:0]   snap_q, snap_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          tick_s;
    logic [12:0]   word_s;
    logic [3:0]    digit_s;
    logic [3:0]    limit_s;
    logic          blank_s;

    // Prescaler, slot pointer, blink phase and frame snapshot next-state.
    always_comb begin
        tick_s      = (presc_q == PRESC_LAST);
        presc_d     = presc_q + PW'(1);
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        snap_d      = snap_q;
        if (tick_s) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
            // idx_q names the slot being loaded on this tick; slot 0 opens a frame.
            if (idx_q == 2'd0) begin
                snap_d = bus.count;
            end else begin
                snap_d = snap_q;
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Digit selection for the slot being loaded: slot 0 reads the live word
    // so the whole frame agrees with the value captured on that same edge.
    always_comb begin
        word_s  = (idx_q == 2'd0) ? bus.count : snap_q;
        digit_s = 4'd0;
        limit_s = 4'd0;
        case (idx_q)
            2'd0: begin
                digit_s = word_s[3:0];
                limit_s = 4'd9;
            end
            2'd1: begin
                digit_s = {1'b0, word_s[6:4]};
                limit_s = 4'd5;
            end
            2'd2: begin
                digit_s = word_s[10:7];
                limit_s = 4'd9;
            end
            default: begin
                digit_s = {2'b00, word_s[12:11]};
                limit_s = 4'd2;
            end
        endcase
        blank_s = phase_q & bus.blink_mask[idx_q];
    end

    // Pin image: blanked while disabled, reloaded once per slot, held otherwise.
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        if (!bus.en) begin
            an_d  = 4'b1111;
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
        end else if (tick_s) begin
            if (blank_s) begin
                an_d  = 4'b1111;
                seg_d = SEG_OFF;
                dp_d  = 1'b1;
            end else begin
                an_d  = ~(4'b0001 << idx_q);
                seg_d = bcd_to_seg(digit_s, limit_s);
                dp_d  = ~((idx_q == 2'd2) & bus.colon_en);
            end
        end else begin
            an_d  = an_q;
            seg_d = seg_q;
            dp_d  = dp_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q     <= '0;
            idx_q       <= 2'd0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            snap_q      <= 13'd0;
            an_q        <= 4'b1111;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            snap_q      <= snap_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
endmodule

// File: tb/tb_time_display_scanner.sv
// Bench for time_display_scanner: frame vectors, tearing/blink/enable/reset
// sequences and random stimulus against a tick-arithmetic reference model.
module tb_time_display_scanner;
    localparam int DIV = 4;
    localparam int BT  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    time_display_scanner_if bus();

    time_display_scanner #(.REFRESH_DIV(DIV), .BLINK_TICKS(BT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int         n_edges;
    int         frame_word;
    int         last_slot;
    bit         just_ticked;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic [6:0] seg_tbl [10];

    localparam logic [11:0] OFF = {4'b1111, 7'b1111111, 1'b1};

    typedef struct {
        logic [12:0]      count;
        logic             colon;
        logic [3:0][11:0] exp;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: an/seg/dp got %b_%b_%b required %b_%b_%b", name,
                      act[11:8], act[7:1], act[0], req[11:8], req[7:1], req[0]);
    endtask

    function automatic logic [6:0] ref_seg(input int w, input int slot);
        int v;
        int lim;
        case (slot)
            0:       begin v = w % 16;         lim = 9; end
            1:       begin v = (w / 16) % 8;   lim = 5; end
            2:       begin v = (w / 128) % 16; lim = 9; end
            default: begin v = w / 2048;       lim = 2; end
        endcase
        if (v > lim) return 7'b0111111;
        return seg_tbl[v];
    endfunction

    task automatic model_off();
        exp_an  = 4'b1111;
        exp_seg = 7'b1111111;
        exp_dp  = 1'b1;
    endtask

    // tick k (1-based since reset) shows slot (k-1)%4 with blink phase ((k-1)/BT)%2
    task automatic model_edge();
        int k;
        n_edges++;
        just_ticked = 1'b0;
        if (n_edges % DIV == 0) begin
            k = n_edges / DIV;
            last_slot = (k - 1) % 4;
            just_ticked = 1'b1;
            if (last_slot == 0) frame_word = int'(bus.count);
            if (bus.en) begin
                if ((((k - 1) / BT) % 2) == 1 && bus.blink_mask[last_slot]) model_off();
                else begin
                    exp_an  = 4'b1111 ^ (4'b0001 << last_slot);
                    exp_seg = ref_seg(frame_word, last_slot);
                    exp_dp  = (last_slot == 2 && bus.colon_en) ? 1'b0 : 1'b1;
                end
            end
        end
        if (!bus.en) model_off();
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check(tag, {bus.an, bus.seg, bus.dp}, {exp_an, exp_seg, exp_dp});
    endtask

    task automatic advance_to(input int s);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            step("model");
            if (just_ticked && last_slot == s) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            $display("FAIL align: slot %0d not reached", s);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("reset_async", {bus.an, bus.seg, bus.dp}, OFF);
        repeat (2) begin
            @(negedge clk);
            check("reset_hold", {bus.an, bus.seg, bus.dp}, OFF);
        end
        rst = 1'b1;
        n_edges = 0;
        frame_word = 0;
        just_ticked = 1'b0;
        model_off();
    endtask

    initial begin
        seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        tbl[0] = '{13'h934, 1'b1, {{4'b0111, 7'b1111001, 1'b1}, {4'b1011, 7'b0100100, 1'b0},
                                   {4'b1101, 7'b0110000, 1'b1}, {4'b1110, 7'b0011001, 1'b1}}};
        tbl[1] = '{13'h11D9, 1'b0, {{4'b0111, 7'b0100100, 1'b1}, {4'b1011, 7'b0110000, 1'b1},
                                    {4'b1101, 7'b0010010, 1'b1}, {4'b1110, 7'b0010000, 1'b1}}};
        tbl[2] = '{13'h47C, 1'b1, {{4'b0111, 7'b1000000, 1'b1}, {4'b1011, 7'b0000000, 1'b0},
                                   {4'b1101, 7'b0111111, 1'b1}, {4'b1110, 7'b0111111, 1'b1}}};
        tbl[3] = '{13'h1D07, 1'b1, {{4'b0111, 7'b0111111, 1'b1}, {4'b1011, 7'b0111111, 1'b0},
                                    {4'b1101, 7'b1000000, 1'b1}, {4'b1110, 7'b1111000, 1'b1}}};
        tbl[4] = '{13'h000, 1'b0, {{4'b0111, 7'b1000000, 1'b1}, {4'b1011, 7'b1000000, 1'b1},
                                   {4'b1101, 7'b1000000, 1'b1}, {4'b1110, 7'b1000000, 1'b1}}};
        tbl[5] = '{13'h14D9, 1'b0, {{4'b0111, 7'b0100100, 1'b1}, {4'b1011, 7'b0010000, 1'b1},
                                    {4'b1101, 7'b0010010, 1'b1}, {4'b1110, 7'b0010000, 1'b1}}};

        bus.count = 13'd0;
        bus.en = 1'b1;
        bus.blink_mask = 4'b0000;
        bus.colon_en = 1'b0;
        apply_reset();

        // first lit slot is digit 0 on the 4th edge after release
        repeat (3) step("post_reset_dark");
        step("post_reset_model");
        check("first_slot", {bus.an, bus.seg, bus.dp}, {4'b1110, 7'b1000000, 1'b1});

        // frame vectors
        for (int v = 0; v < 6; v++) begin
            advance_to(3);
            bus.count = tbl[v].count;
            bus.colon_en = tbl[v].colon;
            for (int s = 0; s < 4; s++) begin
                advance_to(s);
                check($sformatf("vec%0d_slot%0d", v, s), {bus.an, bus.seg, bus.dp}, tbl[v].exp[s]);
            end
        end

        // tearing: word changes mid-frame, frame stays consistent
        advance_to(3);
        bus.count = 13'h934;
        bus.colon_en = 1'b1;
        advance_to(0);
        advance_to(1);
        bus.count = 13'h11D9;
        check("tear_s1", {bus.an, bus.seg, bus.dp}, {4'b1101, 7'b0110000, 1'b1});
        advance_to(2);
        check("tear_s2", {bus.an, bus.seg, bus.dp}, {4'b1011, 7'b0100100, 1'b0});
        advance_to(3);
        check("tear_s3", {bus.an, bus.seg, bus.dp}, {4'b0111, 7'b1111001, 1'b1});
        advance_to(0);
        check("tear_n0", {bus.an, bus.seg, bus.dp}, {4'b1110, 7'b0010000, 1'b1});
        advance_to(1);
        check("tear_n1", {bus.an, bus.seg, bus.dp}, {4'b1101, 7'b0010010, 1'b1});
        advance_to(2);
        check("tear_n2", {bus.an, bus.seg, bus.dp}, {4'b1011, 7'b0110000, 1'b0});
        advance_to(3);
        check("tear_n3", {bus.an, bus.seg, bus.dp}, {4'b0111, 7'b0100100, 1'b1});

        // blink on digits 2 and 3
        bus.count = 13'h934;
        bus.blink_mask = 4'b1100;
        for (int f = 0; f < 3; f++) begin
            advance_to(0);
            check("blink_s0", {bus.an, bus.seg, bus.dp}, {4'b1110, 7'b0011001, 1'b1});
            advance_to(1);
            check("blink_s1", {bus.an, bus.seg, bus.dp}, {4'b1101, 7'b0110000, 1'b1});
            advance_to(2);
            check("blink_s2", {bus.an, bus.seg, bus.dp}, OFF);
            advance_to(3);
            check("blink_s3", {bus.an, bus.seg, bus.dp}, OFF);
        end
        bus.blink_mask = 4'b0000;

        // enable drop mid-slot, then resume at the next tick
        advance_to(1);
        step("en_pre");
        bus.en = 1'b0;
        step("en_drop");
        check("en_off_now", {4'(bus.an), 8'd0}, {4'b1111, 8'd0});
        repeat (2 * DIV) step("en_low");
        check("en_off_held", {bus.an, bus.seg, bus.dp}, OFF);
        bus.en = 1'b1;
        step("en_rise");
        check("en_wait_tick", {bus.an, bus.seg, bus.dp}, OFF);
        for (int i = 0; i < DIV && !just_ticked; i++) step("en_resume");
        check("en_resumed", {bus.an, bus.seg, bus.dp}, {exp_an, exp_seg, exp_dp});

        // reset mid-scan
        advance_to(2);
        step("mid");
        bus.count = 13'd0;
        apply_reset();
        repeat (3) step("rst2_dark");
        step("rst2_first");
        check("rst2_slot0", {bus.an, bus.seg, bus.dp}, {4'b1110, 7'b1000000, 1'b1});

        // random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0)  bus.count = 13'($urandom_range(0, 8191));
            if ($urandom_range(0, 15) == 0) bus.blink_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0)  bus.colon_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) bus.en = ~bus.en;
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
